jk_response_checker: RTL and testbench



---
 rtl/jk_response_checker.sv | 137 +++++++++++++
 tb/tb_jk_response_checker.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_response_checker.sv
// Cycle-accurate JK flip-flop response checker: seeds a reference model from the observed q,
// then compares q/qn every cycle. Define JK_CHK_RESYNC_EN to reload the model on each mismatch.
module jk_response_checker #(
  parameter int ERR_CNT_W = 8,
  parameter int CHK_CNT_W = 16,
  parameter int MAX_ERR   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 j_i,
  input  logic                 k_i,
  input  logic                 q_i,
  input  logic                 qn_i,
  output logic                 exp_q_o,
  output logic                 mismatch_o,
  output logic                 comp_err_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [CHK_CNT_W-1:0] chk_count_o,
  output logic                 fail_o,
  output logic [1:0]           first_err_jk_o,
  output logic                 halted_o
);

  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_e;

  localparam logic [ERR_CNT_W-1:0] MaxErrC = ERR_CNT_W'(MAX_ERR);

  state_e               state_q;
  logic                 expQ_q;
  logic                 mismatch_q;
  logic                 compErr_q;
  logic                 fail_q;
  logic                 halted_q;
  logic                 seenMismatch_q;
  logic [1:0]           prevJk_q;
  logic [1:0]           firstErrJk_q;
  logic [ERR_CNT_W-1:0] errCnt_q;
  logic [CHK_CNT_W-1:0] chkCnt_q;

  logic                 mismatch_d;
  logic                 compErr_d;
  logic                 expQ_d;
  logic [ERR_CNT_W:0]   errSum_d;
  logic [ERR_CNT_W-1:0] errCnt_d;
  logic [CHK_CNT_W-1:0] chkCnt_d;

  function automatic logic jkNext(input logic j, input logic k, input logic q);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // The sum is one bit wider than the counter so a double error can saturate cleanly.
  always_comb begin
    mismatch_d = (q_i != expQ_q);
    compErr_d  = (qn_i == q_i);
    errSum_d   = {1'b0, errCnt_q} + (ERR_CNT_W+1)'(mismatch_d) + (ERR_CNT_W+1)'(compErr_d);
    errCnt_d   = errSum_d[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : errSum_d[ERR_CNT_W-1:0];
    chkCnt_d   = (&chkCnt_q) ? chkCnt_q : chkCnt_q + CHK_CNT_W'(1);
`ifdef JK_CHK_RESYNC_EN
    expQ_d     = mismatch_d ? jkNext(j_i, k_i, q_i) : jkNext(j_i, k_i, expQ_q);
`else
    expQ_d     = jkNext(j_i, k_i, expQ_q);
`endif
  end

  // The flip-flop under check has no reset, so the model is always seeded from observed q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      expQ_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      compErr_q      <= 1'b0;
      fail_q         <= 1'b0;
      halted_q       <= 1'b0;
      seenMismatch_q <= 1'b0;
      prevJk_q       <= 2'b00;
      firstErrJk_q   <= 2'b00;
      errCnt_q       <= '0;
      chkCnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mismatch_q <= 1'b0;
          compErr_q  <= 1'b0;
          if (en_i) begin
            expQ_q   <= jkNext(j_i, k_i, q_i);
            prevJk_q <= {j_i, k_i};
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          mismatch_q <= mismatch_d;
          compErr_q  <= compErr_d;
          errCnt_q   <= errCnt_d;
          chkCnt_q   <= chkCnt_d;
          expQ_q     <= expQ_d;
          prevJk_q   <= {j_i, k_i};
          if (mismatch_d || compErr_d) begin
            fail_q <= 1'b1;
          end
          // prevJk_q holds the inputs that produced the expectation that just failed.
          if (mismatch_d && !seenMismatch_q) begin
            firstErrJk_q   <= prevJk_q;
            seenMismatch_q <= 1'b1;
          end
          if (errCnt_d >= MaxErrC) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (!en_i) begin
            state_q <= IDLE;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign exp_q_o        = expQ_q;
  assign mismatch_o     = mismatch_q;
  assign comp_err_o     = compErr_q;
  assign err_count_o    = errCnt_q;
  assign chk_count_o    = chkCnt_q;
  assign fail_o         = fail_q;
  assign first_err_jk_o = firstErrJk_q;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_jk_response_checker.sv
// Bench for jk_response_checker: a behavioural JK flip-flop with fault hooks drives two checker
// instances (default sizing and a small MAX_ERR=3 one) that are compared against a reference model.
module tb_jk_response_checker;

  logic clk = 1'b0;
  logic rstIn = 1'b1;
  logic enIn = 1'b0;
  logic jIn = 1'b0;
  logic kIn = 1'b0;
  logic qIn = 1'b0;
  logic qnIn = 1'b1;

  logic        exp0, mis0, ce0, fail0, halt0;
  logic [1:0]  first0;
  logic [7:0]  err0;
  logic [15:0] chk0;
  logic        exp1, mis1, ce1, fail1, halt1;
  logic [1:0]  first1;
  logic [1:0]  err1;
  logic [3:0]  chk1;

  int checks = 0;
  int errors = 0;

  // Behavioural flip-flop under check and its fault hooks.
  bit fq;
  bit stuckQ0 = 1'b0;
  bit qnForce = 1'b0;
  bit missToggle = 1'b0;

  // Reference model state, index 0 = default instance, index 1 = small instance.
  bit         mChecking[2];
  bit         mHalted[2];
  bit         mExp[2];
  bit         mMis[2];
  bit         mComp[2];
  bit         mFail[2];
  bit         mSeen[2];
  logic [1:0] mFirst[2];
  logic [1:0] mLastJk[2];
  int         mErr[2];
  int         mChk[2];

  jk_response_checker dut (
    .clk_i(clk), .rst_i(rstIn), .en_i(enIn), .j_i(jIn), .k_i(kIn), .q_i(qIn), .qn_i(qnIn),
    .exp_q_o(exp0), .mismatch_o(mis0), .comp_err_o(ce0), .err_count_o(err0),
    .chk_count_o(chk0), .fail_o(fail0), .first_err_jk_o(first0), .halted_o(halt0)
  );

  jk_response_checker #(.ERR_CNT_W(2), .CHK_CNT_W(4), .MAX_ERR(3)) dutSmall (
    .clk_i(clk), .rst_i(rstIn), .en_i(enIn), .j_i(jIn), .k_i(kIn), .q_i(qIn), .qn_i(qnIn),
    .exp_q_o(exp1), .mismatch_o(mis1), .comp_err_o(ce1), .err_count_o(err1),
    .chk_count_o(chk1), .fail_o(fail1), .first_err_jk_o(first1), .halted_o(halt1)
  );

  always #5 clk = ~clk;

  function automatic bit jkf(bit j, bit k, bit q);
    if (j && k) return !q;
    if (j) return 1'b1;
    if (k) return 1'b0;
    return q;
  endfunction

  function automatic int errSat(int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic int chkSat(int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic int maxErr(int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic modelReset(int i);
    mChecking[i] = 0; mHalted[i] = 0; mExp[i] = 0; mMis[i] = 0; mComp[i] = 0;
    mFail[i] = 0; mSeen[i] = 0; mFirst[i] = 2'b00; mLastJk[i] = 2'b00;
    mErr[i] = 0; mChk[i] = 0;
  endtask

  task automatic modelStep(int i);
    bit mis;
    bit ce;
    if (mHalted[i]) return;
    if (!mChecking[i]) begin
      mMis[i] = 0;
      mComp[i] = 0;
      if (enIn) begin
        mExp[i] = jkf(jIn, kIn, qIn);
        mLastJk[i] = {jIn, kIn};
        mChecking[i] = 1;
      end
      return;
    end
    mis = (qIn != mExp[i]);
    ce = (qnIn == qIn);
    mMis[i] = mis;
    mComp[i] = ce;
    mChk[i] = (mChk[i] + 1 > chkSat(i)) ? chkSat(i) : mChk[i] + 1;
    mErr[i] = mErr[i] + int'(mis) + int'(ce);
    if (mErr[i] > errSat(i)) mErr[i] = errSat(i);
    if (mis || ce) mFail[i] = 1;
    if (mis && !mSeen[i]) begin
      mFirst[i] = mLastJk[i];
      mSeen[i] = 1;
    end
`ifdef JK_CHK_RESYNC_EN
    mExp[i] = mis ? jkf(jIn, kIn, qIn) : jkf(jIn, kIn, mExp[i]);
`else
    mExp[i] = jkf(jIn, kIn, mExp[i]);
`endif
    mLastJk[i] = {jIn, kIn};
    if (mErr[i] >= maxErr(i)) mHalted[i] = 1;
    else if (!enIn) mChecking[i] = 0;
  endtask

  function automatic logic [31:0] modelPack(int i);
    if (i == 0)
      return {1'b0, mExp[0], mMis[0], mComp[0], mFail[0], mFirst[0], mHalted[0],
              8'(mErr[0]), 16'(mChk[0])};
    return {19'b0, mExp[1], mMis[1], mComp[1], mFail[1], mFirst[1], mHalted[1],
            2'(mErr[1]), 4'(mChk[1])};
  endfunction

  task automatic applyPins();
    qIn = stuckQ0 ? 1'b0 : fq;
    qnIn = qnForce ? qIn : ~qIn;
  endtask

  // Advance one edge: models see the same pre-edge pins as the DUTs, then the flip-flop moves.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rstIn) modelReset(i);
      else modelStep(i);
    end
    if (!missToggle) fq = jkf(jIn, kIn, fq);
    missToggle = 0;
    #1;
    applyPins();
  endtask

  task automatic applyStimulus(bit e, bit j, bit k);
    enIn = e;
    jIn = j;
    kIn = k;
    applyPins();
    tick();
  endtask

  task automatic applyReset();
    rstIn = 1'b1;
    stuckQ0 = 0;
    qnForce = 0;
    missToggle = 0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rstIn = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if ({exp0, mis0, ce0, fail0, first0, halt0, err0, chk0} !== 31'd0) begin
      errors++;
      $display("[TB] FAIL reset_default: got %h expected 0",
               {exp0, mis0, ce0, fail0, first0, halt0, err0, chk0});
    end
    checks++;
    if ({exp1, mis1, ce1, fail1, first1, halt1, err1, chk1} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_small: got %h expected 0",
               {exp1, mis1, ce1, fail1, first1, halt1, err1, chk1});
    end
  endtask

  task automatic test_clean_sequence();
    logic [1:0] seq [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    applyReset();
    applyStimulus(1, 0, 0);
    foreach (seq[n]) begin
      applyStimulus(1, seq[n][1], seq[n][0]);
      checks++;
      if (mis0 !== 1'b0 || exp0 !== fq) begin
        errors++;
        $display("[TB] FAIL clean_step%0d: mismatch=%b exp_q=%b expected mismatch=0 exp_q=%b",
                 n, mis0, exp0, fq);
      end
    end
    checks++;
    if (chk0 !== 16'd6 || fail0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_summary: chk=%0d fail=%b expected chk=6 fail=0", chk0, fail0);
    end
  endtask

  task automatic test_comp_err();
    applyReset();
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    qnForce = 1;
    applyStimulus(1, 0, 1);
    qnForce = 0;
    checks++;
    if ({ce0, mis0, fail0, err0} !== {1'b1, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL comp_err_pulse: ce=%b mis=%b fail=%b err=%0d expected 1 0 1 1",
               ce0, mis0, fail0, err0);
    end
    applyStimulus(1, 0, 0);
    checks++;
    if ({ce0, fail0, err0} !== {1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL comp_err_single: ce=%b fail=%b err=%0d expected 0 1 1", ce0, fail0, err0);
    end
  endtask

  task automatic test_stuck_mismatch();
    applyReset();
    stuckQ0 = 1;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checks++;
    if ({mis0, first0, err0} !== {1'b1, 2'b10, 8'd1}) begin
      errors++;
      $display("[TB] FAIL stuck_mismatch: mis=%b first_jk=%b err=%0d expected 1 10 1",
               mis0, first0, err0);
    end
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    checks++;
    if (first0 !== 2'b10) begin
      errors++;
      $display("[TB] FAIL first_jk_hold: got %b expected 10", first0);
    end
  endtask

  task automatic test_toggle_miss();
    int expectErr;
`ifdef JK_CHK_RESYNC_EN
    expectErr = 1;
`else
    expectErr = 5;
`endif
    applyReset();
    applyStimulus(1, 1, 1);
    missToggle = 1;
    applyStimulus(1, 1, 1);
    for (int n = 0; n < 5; n++) applyStimulus(1, 1, 1);
    checks++;
    if (int'(err0) !== expectErr) begin
      errors++;
      $display("[TB] FAIL toggle_miss_err: got %0d expected %0d", err0, expectErr);
    end
  endtask

  task automatic test_halt();
    applyReset();
    stuckQ0 = 1;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checks++;
    if ({halt1, err1} !== {1'b0, 2'd2}) begin
      errors++;
      $display("[TB] FAIL halt_early: halted=%b err=%0d expected 0 2", halt1, err1);
    end
    applyStimulus(1, 1, 0);
    checks++;
    if ({halt1, err1, chk1} !== {1'b1, 2'd3, 4'd3}) begin
      errors++;
      $display("[TB] FAIL halt_enter: halted=%b err=%0d chk=%0d expected 1 3 3", halt1, err1, chk1);
    end
    for (int n = 0; n < 3; n++) applyStimulus(1, 1, 0);
    checks++;
    if ({halt1, err1, chk1} !== {1'b1, 2'd3, 4'd3}) begin
      errors++;
      $display("[TB] FAIL halt_frozen: halted=%b err=%0d chk=%0d expected 1 3 3", halt1, err1, chk1);
    end
    rstIn = 1'b1;
    applyStimulus(1, 1, 0);
    rstIn = 1'b0;
    checks++;
    if ({exp1, mis1, ce1, fail1, first1, halt1, err1, chk1} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL halt_reset: got %h expected 0",
               {exp1, mis1, ce1, fail1, first1, halt1, err1, chk1});
    end
  endtask

  task automatic test_saturation();
    applyReset();
    stuckQ0 = 1;
    qnForce = 1;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checks++;
    if ({halt1, err1, mis1, ce1} !== {1'b0, 2'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL double_error: halted=%b err=%0d mis=%b ce=%b expected 0 2 1 1",
               halt1, err1, mis1, ce1);
    end
    applyStimulus(1, 1, 0);
    checks++;
    if ({halt1, err1} !== {1'b1, 2'd3}) begin
      errors++;
      $display("[TB] FAIL err_saturate: halted=%b err=%0d expected 1 3", halt1, err1);
    end
    applyReset();
    applyStimulus(1, 0, 0);
    for (int n = 0; n < 18; n++) applyStimulus(1, 1'($urandom), 1'($urandom));
    checks++;
    if (chk1 !== 4'd15 || chk0 !== 16'd18) begin
      errors++;
      $display("[TB] FAIL chk_saturate: small=%0d default=%0d expected 15 18", chk1, chk0);
    end
  endtask

  // Compares before the drop, the drop edge itself, then compares after the reseed edge.
  task automatic test_enable_gap();
    applyReset();
    applyStimulus(1, 1, 1);
    for (int n = 0; n < 3; n++) applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 1);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 1, 1);
      checks++;
      if (mis0 !== 1'b0 || exp0 !== fq) begin
        errors++;
        $display("[TB] FAIL reseed_step%0d: mismatch=%b exp_q=%b expected 0 %b", n, mis0, exp0, fq);
      end
    end
    checks++;
    if (chk0 !== 16'd7 || fail0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_gap_count: chk=%0d fail=%b expected 7 0", chk0, fail0);
    end
  endtask

  task automatic test_random();
    logic [31:0] obs;
    applyReset();
    for (int n = 0; n < 400; n++) begin
      rstIn = ($urandom_range(0, 59) == 0);
      qnForce = ($urandom_range(0, 11) == 0);
      missToggle = ($urandom_range(0, 11) == 0);
      applyStimulus(($urandom_range(0, 99) < 85), 1'($urandom), 1'($urandom));
      obs = {1'b0, exp0, mis0, ce0, fail0, first0, halt0, err0, chk0};
      checks++;
      if (obs !== modelPack(0)) begin
        errors++;
        $display("[TB] FAIL random_default cycle %0d: got %h expected %h", n, obs, modelPack(0));
      end
      obs = {19'b0, exp1, mis1, ce1, fail1, first1, halt1, err1, chk1};
      checks++;
      if (obs !== modelPack(1)) begin
        errors++;
        $display("[TB] FAIL random_small cycle %0d: got %h expected %h", n, obs, modelPack(1));
      end
    end
    rstIn = 1'b0;
    qnForce = 0;
  endtask

  initial begin
    fq = 1'($urandom);
    applyPins();
    #2;
    test_reset();
    test_clean_sequence();
    test_comp_err();
    test_stuck_mismatch();
    test_toggle_miss();
    test_halt();
    test_saturation();
    test_enable_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
